iob_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences an external two-port RAM (one write port, one registered read port, 2**ADDR_W words) as a first-in first-out buffer. It owns the read and write pointers, generates the RAM enables and addresses, and reports occupancy. The block sits between a producer/consumer pair and the RAM instance. It contains no storage of its own beyond pointers and flags.

---
 rtl/iob_fifo_ctrl.sv | 71 +++++++
 tb/tb_iob_fifo_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_ctrl.sv
// FIFO controller that sequences an external two-port RAM (registered read port) as a FIFO.
// Holds only the read/write pointers, the pop_valid flag and the overflow/underflow pulses.
module iob_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_addr,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            pop_acc;
    logic            push_acc;

    // The extra MSB on each pointer separates full from empty when the low bits match.
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

    // rst_n gates acceptance so the RAM sees no enables while reset is held.
    assign pop_acc  = pop & ~empty & ~clr & rst_n;
    assign push_acc = push & (~full | pop_acc) & ~clr & rst_n;

    assign ram_w_en    = push_acc;
    assign ram_w_addr  = wptr[ADDR_W-1:0];
    assign ram_data_in = push_data;
    assign ram_r_en    = pop_acc;
    assign ram_r_addr  = rptr[ADDR_W-1:0];
    assign pop_data    = ram_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            overflow  <= push & ~push_acc & ~clr;
            underflow <= pop & ~pop_acc & ~clr;
            if (clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                wptr <= wptr + {{ADDR_W{1'b0}}, push_acc};
                rptr <= rptr + {{ADDR_W{1'b0}}, pop_acc};
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo_ctrl.sv
// Randomised and directed bench for iob_fifo_ctrl, with a behavioural RAM and a queue-based reference model.
`timescale 1ns/1ps
module tb_iob_fifo_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic              ram_w_en;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_r_en;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_data_out;

    int total = 0;
    int bad   = 0;

    iob_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .push(push), .push_data(push_data), .full(full),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .empty(empty), .level(level),
        .overflow(overflow), .underflow(underflow),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_data_in(ram_data_in),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write RAM with a registered read port.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_data_in;
        if (ram_r_en) ram_data_out <= mem[ram_r_addr];
    end

    // Reference model: queue of stored words plus write/read counts since the last clear.
    logic [DATA_W-1:0] ref_q [$];
    int                wr_cnt, rd_cnt;
    logic              exp_valid, exp_ovf, exp_unf;
    logic [DATA_W-1:0] exp_data;
    logic              exp_w_en, exp_r_en;
    logic [ADDR_W-1:0] exp_w_addr, exp_r_addr;
    logic              obs_w_en, obs_r_en;
    logic [ADDR_W-1:0] obs_w_addr, obs_r_addr;
    logic [DATA_W-1:0] obs_din, exp_din;

    task automatic model_reset();
        ref_q.delete();
        wr_cnt = 0; rd_cnt = 0;
        exp_valid = 0; exp_ovf = 0; exp_unf = 0; exp_data = '0;
    endtask

    // Drives one cycle starting at a negedge and returns at the following negedge.
    task automatic tick(input logic p, input logic [DATA_W-1:0] d, input logic q, input logic c);
        logic pa, wa;
        push = p; push_data = d; pop = q; clr = c;
        #1;
        obs_w_en = ram_w_en; obs_w_addr = ram_w_addr; obs_din = ram_data_in;
        obs_r_en = ram_r_en; obs_r_addr = ram_r_addr;
        pa = q && !c && (ref_q.size() > 0);
        wa = p && !c && ((ref_q.size() < DEPTH) || pa);
        exp_w_en = wa; exp_r_en = pa; exp_din = d;
        exp_w_addr = ADDR_W'(wr_cnt % DEPTH);
        exp_r_addr = ADDR_W'(rd_cnt % DEPTH);
        exp_valid = pa;
        exp_ovf = p && !wa && !c;
        exp_unf = q && !pa && !c;
        if (pa) begin exp_data = ref_q.pop_front(); rd_cnt++; end
        if (wa) begin ref_q.push_back(d); wr_cnt++; end
        if (c) begin ref_q.delete(); wr_cnt = 0; rd_cnt = 0; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; clr = 0; push = 1; push_data = 16'h5555; pop = 1;
        model_reset();
        #3;
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", full); end
        total++; if (level !== 7'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
        total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pop_valid got=%b want=0", pop_valid); end
        total++; if (ram_w_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_w_en got=%b want=0", ram_w_en); end
        total++; if (ram_r_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_r_en got=%b want=0", ram_r_en); end
        push = 0; pop = 0;
        @(negedge clk);
        rst_n = 1;
        tick(0, '0, 0, 0);
        total++; if (empty !== 1'b1 || level !== 7'd0 || overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("[TB] FAIL idle_state got empty=%b level=%0d ovf=%b unf=%b want 1/0/0/0", empty, level, overflow, underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1, DATA_W'(i), 0, 0);
            total++; if (obs_w_en !== 1'b1 || obs_w_addr !== ADDR_W'(i - 1))
                begin bad++; $display("[TB] FAIL fill_write got en=%b addr=%0d want en=1 addr=%0d", obs_w_en, obs_w_addr, i - 1); end
            total++; if (level !== 7'(i)) begin bad++; $display("[TB] FAIL fill_level got=%0d want=%0d", level, i); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b want=1", full); end
        total++; if (empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty got=%b want=0", empty); end
    endtask

    task automatic test_overflow();
        tick(1, 16'hBEEF, 0, 0);
        total++; if (obs_w_en !== 1'b0) begin bad++; $display("[TB] FAIL ovf_w_en got=%b want=0", obs_w_en); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pulse got=%b want=1", overflow); end
        total++; if (level !== 7'd64) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=64", level); end
        tick(0, '0, 0, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_one_cycle got=%b want=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] want;
        tick(1, 16'hBEEF, 1, 0);
        total++; if (obs_w_en !== 1'b1 || obs_r_en !== 1'b1 || obs_w_addr !== obs_r_addr)
            begin bad++; $display("[TB] FAIL fullpp_ram got w_en=%b r_en=%b waddr=%0d raddr=%0d want 1/1 same", obs_w_en, obs_r_en, obs_w_addr, obs_r_addr); end
        total++; if (pop_valid !== 1'b1 || pop_data !== 16'h0001)
            begin bad++; $display("[TB] FAIL fullpp_data got v=%b d=%h want v=1 d=0001", pop_valid, pop_data); end
        total++; if (level !== 7'd64) begin bad++; $display("[TB] FAIL fullpp_level got=%0d want=64", level); end
        // Drain: words 2..64 then the word written during the full push+pop.
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, '0, 1, 0);
            want = (i == DEPTH - 1) ? 16'hBEEF : DATA_W'(i + 2);
            total++; if (pop_valid !== 1'b1 || pop_data !== want)
                begin bad++; $display("[TB] FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, pop_valid, pop_data, want); end
        end
        total++; if (empty !== 1'b1 || level !== 7'd0) begin bad++; $display("[TB] FAIL drain_empty got empty=%b level=%0d want 1/0", empty, level); end
        tick(0, '0, 0, 0);
        total++; if (pop_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_idle_valid got=%b want=0", pop_valid); end
    endtask

    task automatic test_underflow();
        tick(0, '0, 1, 0);
        total++; if (obs_r_en !== 1'b0) begin bad++; $display("[TB] FAIL unf_r_en got=%b want=0", obs_r_en); end
        total++; if (underflow !== 1'b1 || pop_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL unf_first got unf=%b v=%b want 1/0", underflow, pop_valid); end
        tick(1, 16'h1234, 1, 0);
        total++; if (underflow !== 1'b1 || pop_valid !== 1'b0 || level !== 7'd1)
            begin bad++; $display("[TB] FAIL unf_with_push got unf=%b v=%b level=%0d want 1/0/1", underflow, pop_valid, level); end
        tick(0, '0, 1, 0);
        total++; if (pop_valid !== 1'b1 || pop_data !== 16'h1234 || underflow !== 1'b0)
            begin bad++; $display("[TB] FAIL unf_next_pop got v=%b d=%h unf=%b want 1/1234/0", pop_valid, pop_data, underflow); end
    endtask

    task automatic test_random();
        logic p, q;
        logic [DATA_W-1:0] d;
        int errs;
        errs = 0;
        for (int n = 0; n < 200; n++) begin
            p = ($urandom_range(0, 99) < 65);
            q = ($urandom_range(0, 99) < 50);
            d = DATA_W'($urandom);
            tick(p, d, q, 0);
            total++;
            if (level !== 7'(ref_q.size()) || empty !== (ref_q.size() == 0) || full !== (ref_q.size() == DEPTH)
                || pop_valid !== exp_valid || (exp_valid && pop_data !== exp_data)
                || overflow !== exp_ovf || underflow !== exp_unf
                || obs_w_en !== exp_w_en || obs_r_en !== exp_r_en
                || (exp_w_en && (obs_w_addr !== exp_w_addr || obs_din !== exp_din))
                || (exp_r_en && obs_r_addr !== exp_r_addr)) begin
                bad++;
                $display("[TB] FAIL random_%0d got lvl=%0d v=%b d=%h ovf=%b unf=%b we=%b wa=%0d re=%b ra=%0d want lvl=%0d v=%b d=%h ovf=%b unf=%b we=%b wa=%0d re=%b ra=%0d",
                         n, level, pop_valid, pop_data, overflow, underflow, obs_w_en, obs_w_addr, obs_r_en, obs_r_addr,
                         ref_q.size(), exp_valid, exp_data, exp_ovf, exp_unf, exp_w_en, exp_w_addr, exp_r_en, exp_r_addr);
            end
        end
        total++; if (wr_cnt <= DEPTH) begin bad++; $display("[TB] FAIL random_wrap got writes=%0d want >%0d", wr_cnt, DEPTH); end
    endtask

    task automatic test_clear();
        while (ref_q.size() > 10) tick(0, '0, 1, 0);
        while (ref_q.size() < 10) tick(1, DATA_W'($urandom), 0, 0);
        total++; if (level !== 7'd10) begin bad++; $display("[TB] FAIL clr_setup got=%0d want=10", level); end
        tick(1, 16'hAAAA, 1, 1);
        total++; if (obs_w_en !== 1'b0 || obs_r_en !== 1'b0)
            begin bad++; $display("[TB] FAIL clr_ram got w_en=%b r_en=%b want 0/0", obs_w_en, obs_r_en); end
        total++; if (level !== 7'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0)
            begin bad++; $display("[TB] FAIL clr_state got lvl=%0d empty=%b v=%b ovf=%b unf=%b want 0/1/0/0/0", level, empty, pop_valid, overflow, underflow); end
        tick(1, 16'h0F0F, 0, 0);
        total++; if (obs_w_addr !== 6'd0 || level !== 7'd1)
            begin bad++; $display("[TB] FAIL clr_restart got waddr=%0d lvl=%0d want 0/1", obs_w_addr, level); end
    endtask

    task automatic test_reset_mid_pop();
        tick(1, 16'h7777, 0, 0);
        tick(1, 16'h8888, 1, 0);
        total++; if (pop_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstpop_pre got v=%b want=1", pop_valid); end
        push = 1; pop = 1;
        #1 rst_n = 0;
        #1;
        model_reset();
        total++; if (pop_valid !== 1'b0 || empty !== 1'b1 || level !== 7'd0)
            begin bad++; $display("[TB] FAIL rstpop_async got v=%b empty=%b lvl=%0d want 0/1/0", pop_valid, empty, level); end
        total++; if (ram_w_en !== 1'b0 || ram_r_en !== 1'b0)
            begin bad++; $display("[TB] FAIL rstpop_ram got w_en=%b r_en=%b want 0/0", ram_w_en, ram_r_en); end
        push = 0; pop = 0;
        @(negedge clk);
        rst_n = 1;
        tick(0, '0, 1, 0);
        total++; if (underflow !== 1'b1 || pop_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL rstpop_after got unf=%b v=%b want 1/0", underflow, pop_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_random();
        test_clear();
        test_reset_mid_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
